filtro_botoes_jogadores: RTL
============================

// Module: filtro_botoes_jogadores
// PURPOSE
//  Input-conditioning stage in front of the player-choice register.
//  - Synchronises and debounces the five player buttons plus the "pular" (skip) button.
//  - Encodes a single clean press into a 3-bit player code with a one-cycle valid strobe.
//  - Locks out further choices until every button has been released.
//  - Downstream, the control unit consumes escolha_valida and the data path
//    consumes jogador_escolhido during night actions and voting.
// PARAMETERS
//  ESTAVEL_MS  4   number of consecutive tick_1k samples a level must hold to be accepted
//  CNT_W       3   counter width; must satisfy 2**CNT_W >= ESTAVEL_MS
// PORTS
//  clock            in   1  system clock (only clock)
//  reset            in   1  asynchronous, active-high reset
//  tick_1k          in   1  one-cycle enable strobe at 1 kHz, synchronous to clock
//  botoes           in   6  active-high; bits [4:0] = players 0..4, bit [5] = pular
//  habilita         in   1  accept new presses only while high
//  limpa            in   1  sync clear of the held choice (start of a new round)
//  jogador_escolhido out 3 0..4 = player, 5 = pular, 7 = no choice
//  escolha_valida   out  1  one-cycle pulse when jogador_escolhido is updated
//  conflito         out  1  one-cycle pulse: more than one button held stably
//  db_estado        out  2  current FSM state, for 7-segment debug
// BEHAVIOUR
//  Synchroniser
//  - botoes passes through a 2-flop synchroniser; all logic uses the synchronised value s.
//  - Synchroniser flops reset to 0.
//  Reset values
//  - jogador_escolhido = 3'd7; escolha_valida = 0; conflito = 0.
//  - State = OCIOSO (2'd0); counter = 0; sample register = 0.
//  States
//  - OCIOSO(0): if habilita && s!=0 -> FILTRANDO; amostra<=s, cnt<=0.
//  - FILTRANDO(1): acts only on cycles with tick_1k=1:
//      - s==amostra: cnt<=cnt+1.
//      - s==0: -> OCIOSO (bounce discarded).
//      - otherwise: amostra<=s, cnt<=0 (restart).
//      - Acceptance is on the tick where cnt==ESTAVEL_MS-1 and s==amostra.
//      - If exactly one bit of amostra is set: jogador_escolhido<=its index
//        (bit5 -> 5) and escolha_valida=1 on the following cycle.
//      - Otherwise conflito=1 on the following cycle and jogador_escolhido is unchanged.
//      - In both cases -> SOLTAR with cnt<=0.
//  - SOLTAR(2): counts ticks while s==0; any tick with s!=0 sets cnt<=0.
//      - On the tick where cnt==ESTAVEL_MS-1 and s==0: -> OCIOSO.
//  - State 3 is unused; the FSM recovers from it to OCIOSO on the next clock.
//  Latency
//  - Pulse appears 1 clock after the ESTAVEL_MS-th consecutive stable tick.
//  - That is 2 extra clocks of synchroniser delay after the edge on botoes.
//  Priorities (highest first)
//  - reset > limpa > habilita falling > normal transitions.
//  - limpa: jogador_escolhido<=7, cnt<=0, state -> SOLTAR.
//    A button still held after a round clear must be released before it can count.
//    No pulse is emitted in the limpa cycle.
//  - habilita low while in FILTRANDO: -> SOLTAR, no pulse.
//    In SOLTAR and OCIOSO habilita has no effect except blocking the OCIOSO exit.
//  Pulses and output hold
//  - escolha_valida and conflito are never high together.
//  - Each is high for exactly one clock.
//  - jogador_escolhido holds its value until the next accepted press or limpa.
//  Counter rules
//  - cnt saturates at ESTAVEL_MS-1; it never wraps.
//  - tick_1k held high for several clocks counts as one tick per clock.
//    This is legal, and is used for fast simulation.
// TESTING (ESTAVEL_MS=4; tick every 10 clocks)
//  - Reset: assert reset mid-FILTRANDO -> state 0, jogador_escolhido=7, no pulses.
//  - Clean press: botoes=6'b000100 held 60 clocks, habilita=1
//    -> one escolha_valida, jogador_escolhido=2, db_estado=2 until release +4 ticks.
//  - Bounce: botoes toggles 000001/000000 every 7 clocks for 50 clocks, then holds 000001
//    -> no pulse during bouncing, exactly one pulse after 4 stable ticks, value 0.
//  - Skip and conflict:
//      - botoes=6'b100000 -> jogador_escolhido=5 with pulse.
//      - After release, botoes=6'b000011 held -> conflito pulse, value stays 5.
//  - Lockout: hold 000010 for 200 clocks -> exactly one pulse.
//    Pressing 001000 while 000010 is held -> no new pulse until all released.
//  - limpa and habilita:
//      - limpa while a button is held -> output 7; no pulse until release and re-press.
//      - habilita=0 with a press -> no pulse.
//      - habilita dropped mid-filter -> state 2, no pulse.

Source files
------------

// File: rtl/filtro_botoes_jogadores.sv
// Debounced player-button filter: synchronises, debounces and encodes one clean press
// into a 3-bit player code, then locks out new choices until every button is released.
module filtro_botoes_jogadores #(
    parameter int ESTAVEL_MS = 4,
    parameter int CNT_W      = 3
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       tick_1k_i,
    input  logic [5:0] botoes_i,
    input  logic       habilita_i,
    input  logic       limpa_i,
    output logic [2:0] jogador_escolhido_o,
    output logic       escolha_valida_o,
    output logic       conflito_o,
    output logic [1:0] db_estado_o
);

    // state     | meaning
    // OCIOSO    | waiting for a press (only while habilita)
    // FILTRANDO | press seen, counting stable ticks of the same pattern
    // SOLTAR    | choice made or cleared, waiting for a stable all-released
    // INVALIDO  | unreachable, recovers to OCIOSO
    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        FILTRANDO = 2'd1,
        SOLTAR    = 2'd2,
        INVALIDO  = 2'd3
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ESTAVEL_MS - 1);

    estado_t          estado_q, estado_d;
    logic [5:0]       sync1_q, s_q;
    logic [5:0]       amostra_q, amostra_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       jogador_q, jogador_d;
    logic             valida_q, valida_d;
    logic             conflito_q, conflito_d;

    logic             s_zero, s_igual, cnt_fim, unico;
    logic [2:0]       indice;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 6'd0;
            s_q     <= 6'd0;
        end else begin
            sync1_q <= botoes_i;
            s_q     <= sync1_q;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            estado_q   <= OCIOSO;
            amostra_q  <= 6'd0;
            cnt_q      <= '0;
            jogador_q  <= 3'd7;
            valida_q   <= 1'b0;
            conflito_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            amostra_q  <= amostra_d;
            cnt_q      <= cnt_d;
            jogador_q  <= jogador_d;
            valida_q   <= valida_d;
            conflito_q <= conflito_d;
        end
    end

    assign s_zero  = (s_q == 6'd0);
    assign s_igual = (s_q == amostra_q);
    assign cnt_fim = (cnt_q == CNT_MAX);
    // exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
    assign unico   = (amostra_q != 6'd0) && ((amostra_q & (amostra_q - 6'd1)) == 6'd0);

    always_comb begin
        indice = 3'd7;
        for (int i = 0; i < 6; i++) begin
            if (amostra_q[i]) indice = 3'(i);
        end
    end

    always_comb begin
        estado_d   = estado_q;
        amostra_d  = amostra_q;
        cnt_d      = cnt_q;
        jogador_d  = jogador_q;
        valida_d   = 1'b0;
        conflito_d = 1'b0;

        if (limpa_i) begin
            jogador_d = 3'd7;
            cnt_d     = '0;
            estado_d  = SOLTAR;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (habilita_i && !s_zero) begin
                        estado_d  = FILTRANDO;
                        amostra_d = s_q;
                        cnt_d     = '0;
                    end
                end
                FILTRANDO: begin
                    if (!habilita_i) begin
                        estado_d = SOLTAR;
                        cnt_d    = '0;
                    end else if (tick_1k_i) begin
                        if (s_zero) begin
                            estado_d = OCIOSO;
                            cnt_d    = '0;
                        end else if (!s_igual) begin
                            amostra_d = s_q;
                            cnt_d     = '0;
                        end else if (cnt_fim) begin
                            if (unico) begin
                                jogador_d = indice;
                                valida_d  = 1'b1;
                            end else begin
                                conflito_d = 1'b1;
                            end
                            estado_d = SOLTAR;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                SOLTAR: begin
                    if (tick_1k_i) begin
                        if (!s_zero) begin
                            cnt_d = '0;
                        end else if (cnt_fim) begin
                            estado_d = OCIOSO;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    assign jogador_escolhido_o = jogador_q;
    assign escolha_valida_o    = valida_q;
    assign conflito_o          = conflito_q;
    assign db_estado_o         = estado_q;

endmodule
